// File: rtl/sobel_window_gen_pkg.sv
//==============================================================================
// Module   : sobel_window_gen_pkg
// Purpose  : Shared defaults, counter widths and the 3x3 window record used by
//            the window generator and the downstream sobel stage.
// Revision : 1.0
//==============================================================================
`default_nettype none

package sobel_window_gen_pkg;

    localparam int c_pix_w = 8;
    localparam int c_img_w = 320;
    localparam int c_img_h = 240;
    localparam int c_col_w = $clog2(c_img_w);
    localparam int c_row_w = $clog2(c_img_h);

    // pRC: R = row (0 oldest), C = column (0 leftmost)
    typedef struct packed {
        logic [c_pix_w-1:0] p00;
        logic [c_pix_w-1:0] p01;
        logic [c_pix_w-1:0] p02;
        logic [c_pix_w-1:0] p10;
        logic [c_pix_w-1:0] p11;
        logic [c_pix_w-1:0] p12;
        logic [c_pix_w-1:0] p20;
        logic [c_pix_w-1:0] p21;
        logic [c_pix_w-1:0] p22;
    } sobel_win_t;

endpackage

`default_nettype wire

// File: rtl/sobel_line_buffer.sv
//==============================================================================
// Module   : sobel_line_buffer
// Purpose  : One-line pixel store; read returns the pre-write contents of the
//            addressed entry, the write lands on the enabled clock edge.
// Revision : 1.0
//==============================================================================
`default_nettype none

module sobel_line_buffer
    import sobel_window_gen_pkg::*;
#(
    parameter int DEPTH  = c_img_w,
    parameter int WIDTH  = c_pix_w,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    output logic [WIDTH-1:0]  o_rd_data
);

    // Storage is deliberately not reset; consumers gate stale data themselves.
    logic [WIDTH-1:0] r_mem [DEPTH];

    assign o_rd_data = r_mem[i_addr];

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_mem[i_addr] <= i_wr_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/sobel_window_gen.sv
//==============================================================================
// Module   : sobel_window_gen
// Purpose  : Builds a registered 3x3 pixel window from a raster pixel stream
//            using two line buffers and per-row column shift registers.
// Revision : 1.0
//==============================================================================
`default_nettype none

module sobel_window_gen
    import sobel_window_gen_pkg::*;
#(
    parameter int IMG_W = c_img_w,
    parameter int IMG_H = c_img_h,
    parameter int PIX_W = c_pix_w
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_data,
    input  logic             sof,
    output logic [PIX_W-1:0] p00,
    output logic [PIX_W-1:0] p01,
    output logic [PIX_W-1:0] p02,
    output logic [PIX_W-1:0] p10,
    output logic [PIX_W-1:0] p11,
    output logic [PIX_W-1:0] p12,
    output logic [PIX_W-1:0] p20,
    output logic [PIX_W-1:0] p21,
    output logic [PIX_W-1:0] p22,
    output logic             win_valid,
    output logic             frame_done
);

    localparam int c_col_w_l = $clog2(IMG_W);
    localparam int c_row_w_l = $clog2(IMG_H);
    localparam logic [c_col_w_l-1:0] c_col_last = c_col_w_l'(IMG_W - 1);
    localparam logic [c_row_w_l-1:0] c_row_last = c_row_w_l'(IMG_H - 1);
    localparam logic [c_col_w_l-1:0] c_col_two  = c_col_w_l'(2);
    localparam logic [c_row_w_l-1:0] c_row_two  = c_row_w_l'(2);

    logic [c_col_w_l-1:0] r_col;
    logic [c_row_w_l-1:0] r_row;
    logic [c_col_w_l-1:0] w_col;
    logic [c_row_w_l-1:0] w_row;
    logic [c_col_w_l-1:0] w_col_nxt;
    logic [c_row_w_l-1:0] w_row_nxt;
    logic                 w_win;
    logic                 w_last;
    logic                 w_lb_en;

    logic [PIX_W-1:0] w_lb_wr [2];
    logic [PIX_W-1:0] w_lb_rd [2];
    logic [PIX_W-1:0] w_tap   [3];
    logic [PIX_W-1:0] r_sr    [3][2];

    // sof forces the accepted pixel to (0,0) regardless of the counters
    assign w_col   = sof ? '0 : r_col;
    assign w_row   = sof ? '0 : r_row;
    assign w_win   = (w_col >= c_col_two) && (w_row >= c_row_two);
    assign w_last  = (w_col == c_col_last) && (w_row == c_row_last);
    assign w_lb_en = pix_valid && rst_n;

    always_comb begin
        w_col_nxt = w_col + c_col_w_l'(1);
        w_row_nxt = w_row;
        if (w_col == c_col_last) begin
            w_col_nxt = '0;
            w_row_nxt = (w_row == c_row_last) ? '0 : w_row + c_row_w_l'(1);
        end
    end

    // LB0 captures the live pixel, LB1 captures what LB0 held for this column
    assign w_lb_wr[0] = pix_data;
    assign w_lb_wr[1] = w_lb_rd[0];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lb
            sobel_line_buffer #(
                .DEPTH  (IMG_W),
                .WIDTH  (PIX_W),
                .ADDR_W (c_col_w_l)
            ) u_lb (
                .clk       (clk),
                .i_en      (w_lb_en),
                .i_addr    (w_col),
                .i_wr_data (w_lb_wr[gi]),
                .o_rd_data (w_lb_rd[gi])
            );
        end
    endgenerate

    // Each row's 3-entry column register is its live tap plus two stored taps
    assign w_tap[0] = w_lb_rd[1];
    assign w_tap[1] = w_lb_rd[0];
    assign w_tap[2] = pix_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col      <= '0;
            r_row      <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                r_sr[r][0] <= '0;
                r_sr[r][1] <= '0;
            end
            p00 <= '0; p01 <= '0; p02 <= '0;
            p10 <= '0; p11 <= '0; p12 <= '0;
            p20 <= '0; p21 <= '0; p22 <= '0;
        end else if (pix_valid) begin
            r_col      <= w_col_nxt;
            r_row      <= w_row_nxt;
            win_valid  <= w_win;
            frame_done <= w_last;
            for (int r = 0; r < 3; r++) begin
                r_sr[r][0] <= r_sr[r][1];
                r_sr[r][1] <= w_tap[r];
            end
            if (w_win) begin
                p00 <= r_sr[0][0]; p01 <= r_sr[0][1]; p02 <= w_tap[0];
                p10 <= r_sr[1][0]; p11 <= r_sr[1][1]; p12 <= w_tap[1];
                p20 <= r_sr[2][0]; p21 <= r_sr[2][1]; p22 <= w_tap[2];
            end
        end else begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sobel_window_gen.sv
//==============================================================================
// Module   : tb_sobel_window_gen
// Purpose  : Self-checking bench for sobel_window_gen on a 5x4 image against a
//            coordinate/image-array reference model.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_sobel_window_gen;

    localparam int W  = 5;
    localparam int H  = 4;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pix_valid = 1'b0;
    logic          sof = 1'b0;
    logic [PW-1:0] pix_data = '0;
    logic [PW-1:0] p00, p01, p02, p10, p11, p12, p20, p21, p22;
    logic          win_valid, frame_done;

    int n_tests = 0;
    int n_fail  = 0;
    int wcount  = 0;

    int            mx = 0;
    int            my = 0;
    logic [PW-1:0] img [H][W];
    logic [71:0]   exp_win = '0;

    sobel_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .sof        (sof),
        .p00        (p00), .p01 (p01), .p02 (p02),
        .p10        (p10), .p11 (p11), .p12 (p12),
        .p20        (p20), .p21 (p21), .p22 (p22),
        .win_valid  (win_valid),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [71:0] obs_win();
        return {p00, p01, p02, p10, p11, p12, p20, p21, p22};
    endfunction

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock: drive inputs, advance the model, compare after the edge
    task automatic step(input bit v, input bit s, input logic [PW-1:0] d);
        bit exp_wv;
        bit exp_fd;
        @(negedge clk);
        pix_valid = v;
        sof       = s;
        pix_data  = d;
        @(posedge clk);
        #1;
        exp_wv = 1'b0;
        exp_fd = 1'b0;
        if (v) begin
            if (s) begin
                mx = 0;
                my = 0;
            end
            img[my][mx] = d;
            if (mx >= 2 && my >= 2) begin
                exp_wv  = 1'b1;
                exp_win = '0;
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        exp_win = {exp_win[63:0], img[my-2+r][mx-2+c]};
            end
            exp_fd = (mx == W-1) && (my == H-1);
            mx++;
            if (mx == W) begin
                mx = 0;
                my = (my == H-1) ? 0 : my + 1;
            end
        end
        check("win_valid", 72'(win_valid), 72'(exp_wv));
        check("frame_done", 72'(frame_done), 72'(exp_fd));
        check("window", obs_win(), exp_win);
        if (win_valid) wcount++;
    endtask

    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            rst_n     = 1'b0;
            pix_valid = 1'b1;
            sof       = 1'b0;
            pix_data  = 8'hAA;
            @(posedge clk);
            #1;
            check("rst_win_valid", 72'(win_valid), 72'(0));
            check("rst_frame_done", 72'(frame_done), 72'(0));
            check("rst_window", obs_win(), 72'(0));
        end
        @(negedge clk);
        rst_n     = 1'b1;
        pix_valid = 1'b0;
        mx = 0;
        my = 0;
        exp_win = '0;
    endtask

    // n pixels from raster index 0; offset-gradient or random values
    task automatic send_frame(input int n, input int offset, input bit rnd,
                              input int gap_pct, input bit sof_first);
        logic [PW-1:0] d;
        wcount = 0;
        for (int i = 0; i < n; i++) begin
            d = rnd ? PW'($urandom) : PW'(offset + 10*(i/W) + (i%W));
            while (int'($urandom_range(99)) < gap_pct)
                step(1'b0, 1'($urandom_range(1)), PW'($urandom));
            step(1'b1, sof_first && (i == 0), d);
            if (!rnd && offset == 0 && i == 12)
                check("first_window", obs_win(),
                      {8'd0, 8'd1, 8'd2, 8'd10, 8'd11, 8'd12, 8'd20, 8'd21, 8'd22});
            if (!rnd && offset == 0 && i == W*H-1)
                check("last_p22", 72'(p22), 72'(34));
        end
        if (n == W*H)
            check("window_count", 72'(wcount), 72'((W-2)*(H-2)));
    endtask

    initial begin
        do_reset(3);

        // Continuous gradient frame
        send_frame(W*H, 0, 1'b0, 0, 1'b0);
        // Same frame with random idle cycles
        send_frame(W*H, 0, 1'b0, 35, 1'b1);
        // sof on pixel (3,2): partial frame, then a new frame starts at that pixel
        send_frame(13, 0, 1'b0, 0, 1'b1);
        send_frame(W*H, 100, 1'b0, 0, 1'b1);
        // Reset for one cycle after pixel (3,2), then a full frame
        send_frame(14, 0, 1'b0, 0, 1'b1);
        do_reset(1);
        send_frame(W*H, 0, 1'b0, 0, 1'b0);
        // Back-to-back random frames, with and without gaps
        for (int f = 0; f < 4; f++)
            send_frame(W*H, 0, 1'b1, (f >= 2) ? 25 : 0, 1'b0);
        // Idle cycles with stray sof must not disturb state
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, PW'($urandom));
        send_frame(W*H, 50, 1'b0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sobel_window_gen.md
SOBEL_WINDOW_GEN -- requirements
Module: sobel_window_gen

Interface
REQ-001 Parameter IMG_W, default 320, active pixels per line, minimum 3.
REQ-002 Parameter IMG_H, default 240, lines per frame, minimum 3.
REQ-003 Parameter PIX_W, default 8, pixel width in bits.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 pix_valid  input  1  pix_data is accepted on this cycle. There is no backpressure.
REQ-007 pix_data  input  PIX_W  raster-order pixel, left to right, top to bottom.
REQ-008 sof  input  1  start of frame; qualified by pix_valid.
REQ-009 p00..p22  output  PIX_W each (9 ports)  3x3 window, registered; pRC, where R is row (0 = oldest) and C is column (0 = leftmost).
REQ-010 win_valid  output  1  one-cycle pulse marking a new window on p00..p22.
REQ-011 frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-012 The block shall track col (0..IMG_W-1) and row (0..IMG_H-1) of the next accepted pixel, advancing only on pix_valid.
REQ-013 Wrap rules:
- col shall wrap IMG_W-1 -> 0 and increment row.
- At row IMG_H-1 with col IMG_W-1, both col and row shall wrap to 0.
REQ-014 The block shall keep two line buffers, each IMG_W deep:
- LB0 holds row-1 and LB1 holds row-2, both indexed by col.
- On each accepted pixel, read-before-write at address col: LB1[col] <= LB0[col], LB0[col] <= pix_data.
REQ-015 The block shall keep three 3-entry column shift registers, shifted on each accepted pixel:
- bottom row fed by pix_data;
- middle row fed by the LB0 read value;
- top row fed by the LB1 read value.
REQ-016 When the pixel at (x,y) is accepted:
- p22 shall equal pixel (x,y), p00 shall equal pixel (x-2,y-2), and generally pRC = pixel (x-2+C, y-2+R).
- The window is centred on (x-1,y-1).
REQ-017 win_valid shall assert exactly one cycle after accepting a pixel with col>=2 and row>=2, with p00..p22 valid in that same cycle.
REQ-018 Windows never straddle a line wrap or rows 0..1, so there is no border padding; each frame yields exactly (IMG_W-2)*(IMG_H-2) windows.
REQ-019 p00..p22 shall change only in cycles where win_valid is 1 and hold their value otherwise.
REQ-020 Cycles with pix_valid=0 shall change no state, and win_valid and frame_done shall be 0 in those cycles.
REQ-021 When pix_valid=1 and sof=1:
- the pixel shall be treated as (0,0), overriding col/row;
- line buffer contents are not cleared, but no window shall be emitted until row>=2 of the new frame.
REQ-022 sof with pix_valid=0 shall be ignored.
REQ-023 frame_done shall pulse one cycle after accepting pixel (IMG_W-1, IMG_H-1). In that same cycle win_valid also pulses for the final window.
REQ-024 Back-to-back frames with no idle cycles shall be supported.
REQ-025 Throughput shall be one pixel per cycle, sustained.
REQ-026 Counter widths shall be $clog2 of IMG_W and of IMG_H.

Reset
REQ-027 While rst_n=0 at a clock edge:
- col, row, win_valid, frame_done, all shift registers and p00..p22 shall be set to 0;
- pix_valid shall be ignored.
REQ-028 Line buffer storage shall not be reset; stale contents shall never reach the outputs because of REQ-017 gating.
REQ-029 Reset asserted mid-frame shall abort the frame, and the first pixel after reset release shall be treated as (0,0).

Structure
REQ-030 A shared package shall hold:
- the PIX_W default;
- the IMG_W and IMG_H defaults;
- the counter-width constants;
- the 3x3 window record type, shared with the downstream sobel stage.
REQ-031 Sub-module sobel_line_buffer shall provide one IMG_W x PIX_W line store with synchronous read-before-write on a single address and an enable. It is instantiated twice.

Verification (IMG_W=5, IMG_H=4, pixel value = 10*y + x)
REQ-032 Continuous frame, no gaps -> exactly 6 win_valid pulses:
- the first follows pixel (2,2), with p00..p22 = 0,1,2,10,11,12,20,21,22;
- the last has p22=34.
REQ-033 Same frame with pix_valid dropped on random cycles -> an identical window sequence, and no pulses in idle cycles.
REQ-034 Line wrap -> no win_valid after pixels (0,2), (1,2), (0,3), (1,3).
REQ-035 sof asserted on the pixel at (3,2) -> that pixel is counted as (0,0); no window appears until the new row 2, col 2.
REQ-036 rst_n low for 1 cycle after pixel (3,2), then a full frame -> outputs are 0 during reset and the window sequence matches REQ-032.
REQ-037 Two frames back-to-back -> frame_done pulses after (4,3) of each frame; frame 2 windows carry no frame 1 data.
